// File: rtl/cpu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : cpu_pkg                                                      |
// | Shared constants, extension-mode encoding and the 16->32 immediate     |
// | extension helper used by the MIPS pipeline stage registers.            |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package cpu_pkg;

   localparam logic [31:0] NOP_IR       = 32'h0000_0000;
   localparam logic [31:0] PC_STEP      = 32'd4;
   localparam int          STALL_BUBBLE = 0;
   localparam int          STALL_HOLD   = 1;

   typedef enum logic [1:0] {
      EXT_ZERO  = 2'd0,
      EXT_SIGN  = 2'd1,
      EXT_UPPER = 2'd2
   } ext_mode_e;

   // Immediate extension: zero, sign, or shifted into the upper half (lui).
   function automatic logic [31:0] ext16(input logic [15:0] imm, input ext_mode_e mode);
      logic [31:0] w_res;
      case (mode)
         EXT_SIGN:  w_res = {{16{imm[15]}}, imm};
         EXT_UPPER: w_res = {imm, 16'h0000};
         default:   w_res = {16'h0000, imm};
      endcase
      return w_res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : sat_counter                                                  |
// | Up-counter that stops at its all-ones value instead of wrapping.       |
// | Ports   : clk    - rising-edge clock                                   |
// |           rst_n  - asynchronous active-low clear                       |
// |           i_inc  - count enable                                        |
// |           o_cnt  - current count                                       |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_cnt
);

   localparam logic [CNT_W-1:0] c_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != c_MAX)) begin
         r_cnt <= r_cnt + c_ONE;
      end
   end

   assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : pipe_stage_reg                                               |
// | Inter-stage pipeline register for the 5-stage MIPS core (D->E, E->M,   |
// | M->W). Latches IR, PC+4/PC+8, NUM_CH operand channels and immediate    |
// | extensions, with flush, bubble-or-hold stall and saturating counters.  |
// | Ports   : clk, reset (async active-low), stall, flush, valid_in,       |
// |           ir_in, pc_in, ch_in -> valid_out, ir_out, pc4_out, pc8_out,  |
// |           ch_out, ext0_out, ext1_out, extu_out, stall_cnt, bubble_cnt  |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module pipe_stage_reg
   import cpu_pkg::*;
#(
   parameter int DW         = 32,
   parameter int NUM_CH     = 2,
   parameter int STALL_MODE = 0,
   parameter int EXT_EN     = 1,
   parameter int CNT_W      = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 stall,
   input  logic                 flush,
   input  logic                 valid_in,
   input  logic [31:0]          ir_in,
   input  logic [31:0]          pc_in,
   input  logic [NUM_CH*DW-1:0] ch_in,
   output logic                 valid_out,
   output logic [31:0]          ir_out,
   output logic [31:0]          pc4_out,
   output logic [31:0]          pc8_out,
   output logic [NUM_CH*DW-1:0] ch_out,
   output logic [31:0]          ext0_out,
   output logic [31:0]          ext1_out,
   output logic [31:0]          extu_out,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     bubble_cnt
);

   // A stall only counts when flush does not override it.
   logic w_stall_eff;
   logic w_hold;
   logic w_bubble;

   assign w_stall_eff = stall & ~flush;
   assign w_hold      = w_stall_eff & (STALL_MODE == STALL_HOLD);
   assign w_bubble    = flush | (w_stall_eff & (STALL_MODE == STALL_BUBBLE));

   logic        r_valid;
   logic [31:0] r_ir;
   logic [31:0] r_pc4;
   logic [31:0] r_pc8;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid <= 1'b0;
         r_ir    <= NOP_IR;
         r_pc4   <= '0;
         r_pc8   <= '0;
      end else if (w_bubble) begin
         r_valid <= 1'b0;
         r_ir    <= NOP_IR;
         r_pc4   <= '0;
         r_pc8   <= '0;
      end else if (!w_hold) begin
         r_valid <= valid_in;
         r_ir    <= ir_in;
         r_pc4   <= pc_in + PC_STEP;
         r_pc8   <= pc_in + (PC_STEP << 1);
      end
   end

   assign valid_out = r_valid;
   assign ir_out    = r_ir;
   assign pc4_out   = r_pc4;
   assign pc8_out   = r_pc8;

   genvar k;
   generate
      for (k = 0; k < NUM_CH; k++) begin : g_ch
         logic [DW-1:0] r_ch;
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               r_ch <= '0;
            end else if (w_bubble) begin
               r_ch <= '0;
            end else if (!w_hold) begin
               r_ch <= ch_in[k*DW +: DW];
            end
         end
         assign ch_out[k*DW +: DW] = r_ch;
      end
   endgenerate

   generate
      if (EXT_EN != 0) begin : g_ext
         logic [31:0] r_ext0;
         logic [31:0] r_ext1;
         logic [31:0] r_extu;
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               r_ext0 <= '0;
               r_ext1 <= '0;
               r_extu <= '0;
            end else if (w_bubble) begin
               r_ext0 <= '0;
               r_ext1 <= '0;
               r_extu <= '0;
            end else if (!w_hold) begin
               r_ext0 <= ext16(ir_in[15:0], EXT_ZERO);
               r_ext1 <= ext16(ir_in[15:0], EXT_SIGN);
               r_extu <= ext16(ir_in[15:0], EXT_UPPER);
            end
         end
         assign ext0_out = r_ext0;
         assign ext1_out = r_ext1;
         assign extu_out = r_extu;
      end else begin : g_no_ext
         assign ext0_out = '0;
         assign ext1_out = '0;
         assign extu_out = '0;
      end
   endgenerate

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (reset),
      .i_inc (w_stall_eff),
      .o_cnt (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .rst_n (reset),
      .i_inc (w_bubble),
      .o_cnt (bubble_cnt)
   );

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------------+
// | Module  : tb_pipe_stage_reg                                            |
// | Scoreboard bench: three pipe_stage_reg instances (bubble mode, hold    |
// | mode, bubble mode with 2-bit counters) share one randomized stimulus   |
// | stream and are compared against a behavioural model.                  |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_pipe_stage_reg;

   typedef struct packed {
      logic        valid;
      logic [31:0] ir;
      logic [31:0] pc4;
      logic [31:0] pc8;
      logic [63:0] ch;
      logic [31:0] ext0;
      logic [31:0] ext1;
      logic [31:0] extu;
      logic [15:0] stall_cnt;
      logic [15:0] bubble_cnt;
   } snap_t;

   typedef snap_t [2:0] trio_t;

   logic        clk      = 1'b0;
   logic        reset    = 1'b0;
   logic        stall    = 1'b0;
   logic        flush    = 1'b0;
   logic        valid_in = 1'b0;
   logic [31:0] ir_in    = '0;
   logic [31:0] pc_in    = '0;
   logic [63:0] ch_in    = '0;

   logic        v_o   [3];
   logic [31:0] ir_o  [3];
   logic [31:0] pc4_o [3];
   logic [31:0] pc8_o [3];
   logic [63:0] ch_o  [3];
   logic [31:0] e0_o  [3];
   logic [31:0] e1_o  [3];
   logic [31:0] eu_o  [3];
   logic [15:0] sc_o0, bc_o0, sc_o1, bc_o1;
   logic [1:0]  sc_o2, bc_o2;

   always #5 clk = ~clk;

   pipe_stage_reg #(.DW(32), .NUM_CH(2), .STALL_MODE(0), .EXT_EN(1), .CNT_W(16)) u_dut_bub (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
      .ir_in(ir_in), .pc_in(pc_in), .ch_in(ch_in),
      .valid_out(v_o[0]), .ir_out(ir_o[0]), .pc4_out(pc4_o[0]), .pc8_out(pc8_o[0]),
      .ch_out(ch_o[0]), .ext0_out(e0_o[0]), .ext1_out(e1_o[0]), .extu_out(eu_o[0]),
      .stall_cnt(sc_o0), .bubble_cnt(bc_o0));

   pipe_stage_reg #(.DW(32), .NUM_CH(2), .STALL_MODE(1), .EXT_EN(1), .CNT_W(16)) u_dut_hold (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
      .ir_in(ir_in), .pc_in(pc_in), .ch_in(ch_in),
      .valid_out(v_o[1]), .ir_out(ir_o[1]), .pc4_out(pc4_o[1]), .pc8_out(pc8_o[1]),
      .ch_out(ch_o[1]), .ext0_out(e0_o[1]), .ext1_out(e1_o[1]), .extu_out(eu_o[1]),
      .stall_cnt(sc_o1), .bubble_cnt(bc_o1));

   pipe_stage_reg #(.DW(32), .NUM_CH(2), .STALL_MODE(0), .EXT_EN(1), .CNT_W(2)) u_dut_sat (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
      .ir_in(ir_in), .pc_in(pc_in), .ch_in(ch_in),
      .valid_out(v_o[2]), .ir_out(ir_o[2]), .pc4_out(pc4_o[2]), .pc8_out(pc8_o[2]),
      .ch_out(ch_o[2]), .ext0_out(e0_o[2]), .ext1_out(e1_o[2]), .extu_out(eu_o[2]),
      .stall_cnt(sc_o2), .bubble_cnt(bc_o2));

   int    n_checks = 0;
   int    n_pass   = 0;
   int    n_fail   = 0;
   trio_t sb_q[$];
   event  ev_chk;

   // Reference model state: per instance, stall mode and counter ceiling.
   snap_t       m_st  [3];
   int          m_mode[3] = '{0, 1, 0};
   int unsigned m_max [3] = '{65535, 65535, 3};
   string       m_name[3] = '{"bub", "hold", "sat2"};

   function automatic snap_t actual(input int i);
      snap_t s;
      s.valid = v_o[i];
      s.ir    = ir_o[i];
      s.pc4   = pc4_o[i];
      s.pc8   = pc8_o[i];
      s.ch    = ch_o[i];
      s.ext0  = e0_o[i];
      s.ext1  = e1_o[i];
      s.extu  = eu_o[i];
      case (i)
         0:       begin s.stall_cnt = sc_o0; s.bubble_cnt = bc_o0; end
         1:       begin s.stall_cnt = sc_o1; s.bubble_cnt = bc_o1; end
         default: begin s.stall_cnt = {14'd0, sc_o2}; s.bubble_cnt = {14'd0, bc_o2}; end
      endcase
      return s;
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v, input int unsigned mx);
      int unsigned x;
      x = int'(v);
      if (x < mx) x = x + 1;
      return x[15:0];
   endfunction

   function automatic snap_t empty_slot(input snap_t s);
      snap_t n;
      n            = '0;
      n.stall_cnt  = s.stall_cnt;
      n.bubble_cnt = s.bubble_cnt;
      return n;
   endfunction

   // One clock edge of the architectural behaviour, priority flush > stall > load.
   task automatic model_edge(input logic s, input logic f, input logic v,
                             input logic [31:0] ir, input logic [31:0] pc, input logic [63:0] ch);
      snap_t n;
      for (int i = 0; i < 3; i++) begin
         n = m_st[i];
         if (f) begin
            n            = empty_slot(n);
            n.bubble_cnt = sat_inc(n.bubble_cnt, m_max[i]);
         end else if (s) begin
            n.stall_cnt = sat_inc(n.stall_cnt, m_max[i]);
            if (m_mode[i] == 0) begin
               n            = empty_slot(n);
               n.bubble_cnt = sat_inc(n.bubble_cnt, m_max[i]);
            end
         end else begin
            n.valid = v;
            n.ir    = ir;
            n.pc4   = pc + 32'd4;
            n.pc8   = pc + 32'd8;
            n.ch    = ch;
            n.ext0  = {16'h0000, ir[15:0]};
            n.ext1  = (ir[15] == 1'b1) ? ({16'hFFFF, ir[15:0]}) : ({16'h0000, ir[15:0]});
            n.extu  = {ir[15:0], 16'h0000};
         end
         m_st[i] = n;
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) m_st[i] = '0;
   endtask

   task automatic push_exp();
      trio_t t;
      for (int i = 0; i < 3; i++) t[i] = m_st[i];
      sb_q.push_back(t);
   endtask

   task automatic step(input logic s, input logic f, input logic v,
                       input logic [31:0] ir, input logic [31:0] pc, input logic [63:0] ch);
      @(negedge clk);
      reset    = 1'b1;
      stall    = s;
      flush    = f;
      valid_in = v;
      ir_in    = ir;
      pc_in    = pc;
      ch_in    = ch;
      model_edge(s, f, v, ir, pc, ch);
      push_exp();
   endtask

   task automatic rand_step();
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0), 1'($urandom),
           $urandom, $urandom, {$urandom, $urandom});
   endtask

   // Reset dropped between edges: outputs are checked shortly after, then
   // again on the following edge while reset is still low.
   task automatic reset_mid(input int dly);
      @(negedge clk);
      #(dly);
      reset = 1'b0;
      model_reset();
      push_exp();
      -> ev_chk;
      push_exp();
   endtask

   task automatic dcheck(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Monitor: every edge (or mid-cycle reset event) pops one expectation per instance.
   initial begin
      trio_t e;
      snap_t a;
      forever begin
         @(posedge clk or ev_chk);
         #1;
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_underflow: got empty queue want entry at %0t", $time);
         end else begin
            e = sb_q.pop_front();
            for (int i = 0; i < 3; i++) begin
               a = actual(i);
               n_checks++;
               if (a !== e[i]) begin
                  n_fail++;
                  $display("FAIL %s @%0t: got %h want %h", m_name[i], $time, a, e[i]);
               end else begin
                  n_pass++;
               end
            end
         end
      end
   end

   initial begin
      model_reset();
      push_exp();

      // Directed: basic load.
      step(1'b0, 1'b0, 1'b1, 32'h2108FFFF, 32'h0000_3000, 64'h0000_0005_0000_000A);
      @(posedge clk); #2;
      dcheck("t1_ext1", {32'h0, e1_o[0]}, 64'hFFFF_FFFF);
      dcheck("t1_pc8",  {32'h0, pc8_o[0]}, 64'h3008);

      // Three stalls: bubble instance empties, hold instance keeps test-1 data.
      for (int j = 0; j < 3; j++) step(1'b1, 1'b0, 1'b1, $urandom, $urandom, {$urandom, $urandom});
      @(posedge clk); #2;
      dcheck("t2_bub_bcnt", {48'h0, bc_o0}, 64'd3);
      dcheck("t3_hold_ir",  {32'h0, ir_o[1]}, 64'h2108FFFF);
      dcheck("t3_hold_bcnt", {48'h0, bc_o1}, 64'd0);

      // Stall and flush together after a fresh reset.
      reset_mid(2);
      step(1'b1, 1'b1, 1'b1, 32'h1234_5678, 32'h100, 64'hDEAD_BEEF_0000_0001);
      @(posedge clk); #2;
      dcheck("t4_stall_cnt", {48'h0, sc_o1}, 64'd0);

      // PC wrap and counter saturation.
      step(1'b0, 1'b0, 1'b1, 32'h3C01_8000, 32'hFFFF_FFFC, 64'h1);
      @(posedge clk); #2;
      dcheck("t5_pc4", {32'h0, pc4_o[0]}, 64'h0);
      for (int j = 0; j < 5; j++) step(1'b0, 1'b1, 1'b1, $urandom, $urandom, 64'h0);
      @(posedge clk); #2;
      dcheck("t5_sat_bcnt", {62'h0, bc_o2}, 64'd3);

      // Asynchronous reset while loaded, then a normal load.
      step(1'b0, 1'b0, 1'b1, 32'hAC22_0010, 32'h400, 64'h77);
      reset_mid(2);
      step(1'b0, 1'b0, 1'b1, 32'h8C43_FFF0, 32'h404, 64'h55_0000_0066);

      // Randomized traffic with occasional mid-cycle resets.
      for (int j = 0; j < 400; j++) begin
         if ($urandom_range(0, 59) == 0) reset_mid(int'($urandom_range(1, 3)));
         else rand_step();
      end

      @(posedge clk); #3;
      dcheck("sb_drained", 64'(sb_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
